// File: rtl/filter_pkg.sv
// Shared constants and helpers for the greyscale filter pipeline.
package filter_pkg;

    // Default pixel / output width.
    localparam int PIX_W_DEFAULT = 8;

    // Signed gradient width; holds +/-1020 for 8-bit pixels.
    localparam int SOBEL_GW = 11;

    // Magnitude of a signed gradient, shifted right and clamped to max_val.
    function automatic logic [SOBEL_GW-1:0] sat_abs_shift(
        input logic signed [SOBEL_GW-1:0] g,
        input int unsigned                shift,
        input logic [SOBEL_GW-1:0]        max_val
    );
        logic [SOBEL_GW-1:0] mag;
        mag = g[SOBEL_GW-1] ? SOBEL_GW'(-g) : SOBEL_GW'(g);
        mag = mag >> shift;
        return (mag > max_val) ? max_val : mag;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage with a circular pointer. The old word at the
// pointer is visible combinationally and is replaced on the same accepting
// edge, so a read always sees the value from one line earlier.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic             restart_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    ptr_q;
    logic [AW-1:0]    ptr_d;
    logic [AW-1:0]    addr;

    // A restart (start of frame) realigns the pointer to column 0.
    assign addr      = restart_i ? '0 : ptr_q;
    assign rd_data_o = mem_q[addr];

    // Advance the pointer past the word just written, wrapping at DEPTH-1.
    always_comb begin
        ptr_d = ptr_q;
        if (we_i) begin
            ptr_d = (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr] <= wr_data_i;
        end
    end

endmodule

// File: rtl/sobel_gradient.sv
// Streaming 3x3 Sobel stage: raster-order pixels in, saturated |Gx|>>SHIFT
// and |Gy|>>SHIFT out, one result per interior pixel, latency two cycles.
module sobel_gradient
    import filter_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = PIX_W_DEFAULT,
    parameter int SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [PIX_W-1:0] gx_abs,
    output logic [PIX_W-1:0] gy_abs,
    output logic             out_valid,
    output logic             frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [SOBEL_GW-1:0] OUT_MAX = SOBEL_GW'((1 << PIX_W) - 1);

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    logic          restart, mid_sof, trigger, last_pix;

    logic [PIX_W-1:0] lb1_rd, lb2_rd;
    logic [PIX_W-1:0] col_load [3];
    logic [PIX_W-1:0] win_q    [3][3];
    logic signed [SOBEL_GW-1:0] tap [3][3];
    logic signed [SOBEL_GW-1:0] gx_sum, gy_sum;

    logic                       v0_q, last0_q, v1_q, last1_q;
    logic signed [SOBEL_GW-1:0] gxs_q, gys_q;
    logic [SOBEL_GW-1:0]        gx_sat, gy_sat;
    logic [PIX_W-1:0]           gx_q, gy_q;
    logic                       out_valid_q, frame_done_q;

    // sof overrides the counters for the pixel that carries it. It only
    // flushes the pipeline when it interrupts a frame; after a complete frame
    // the counters are already at (0,0) and the last result must survive.
    assign restart  = pix_valid & sof;
    assign col_cur  = sof ? '0 : col_q;
    assign row_cur  = sof ? '0 : row_q;
    assign mid_sof  = restart && ((col_q != '0) || (row_q != '0));
    assign trigger  = pix_valid && (col_cur >= CW'(2)) && (row_cur >= RW'(2));
    assign last_pix = (col_cur == CW'(IMG_W - 1)) && (row_cur == RW'(IMG_H - 1));

    // Raster position of the next pixel.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pix_valid) begin
            if (col_cur == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_cur == RW'(IMG_H - 1)) ? '0 : row_cur + RW'(1);
            end else begin
                col_d = col_cur + CW'(1);
                row_d = row_cur;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Line 1 holds the previous row; line 2 receives what line 1 evicts.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk       (clk),
        .rst       (rst),
        .we_i      (pix_valid),
        .restart_i (restart),
        .wr_data_i (pix_in),
        .rd_data_o (lb1_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
        .clk       (clk),
        .rst       (rst),
        .we_i      (pix_valid),
        .restart_i (restart),
        .wr_data_i (lb1_rd),
        .rd_data_o (lb2_rd)
    );

    assign col_load[0] = lb2_rd;
    assign col_load[1] = lb1_rd;
    assign col_load[2] = pix_in;

    // Window shifts left on every accepted pixel; the new right column is
    // {two rows up, one row up, current}.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
                win_q[r][2] <= col_load[r];
            end
        end
    end

    // Zero-extend the window taps into the signed gradient domain.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                tap[r][c] = $signed({{(SOBEL_GW - PIX_W){1'b0}}, win_q[r][c]});
            end
        end
    end

    assign gx_sum = (tap[0][2] + (tap[1][2] <<< 1) + tap[2][2])
                  - (tap[0][0] + (tap[1][0] <<< 1) + tap[2][0]);
    assign gy_sum = (tap[2][0] + (tap[2][1] <<< 1) + tap[2][2])
                  - (tap[0][0] + (tap[0][1] <<< 1) + tap[0][2]);

    assign gx_sat = sat_abs_shift(gxs_q, SHIFT, OUT_MAX);
    assign gy_sat = sat_abs_shift(gys_q, SHIFT, OUT_MAX);

    // Stage valid bits and gradient sums; an interrupting sof drops in-flight work.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0_q    <= 1'b0;
            last0_q <= 1'b0;
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            gxs_q   <= '0;
            gys_q   <= '0;
        end else begin
            v0_q    <= trigger;
            last0_q <= last_pix;
            v1_q    <= v0_q & ~mid_sof;
            last1_q <= last0_q;
            if (v0_q) begin
                gxs_q <= gx_sum;
                gys_q <= gy_sum;
            end
        end
    end

    // Output register: values hold while no result is being presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gx_q         <= '0;
            gy_q         <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= v1_q & ~mid_sof;
            frame_done_q <= v1_q & last1_q & ~mid_sof;
            if (v1_q && !mid_sof) begin
                gx_q <= gx_sat[PIX_W-1:0];
                gy_q <= gy_sat[PIX_W-1:0];
            end
        end
    end

    assign gx_abs     = gx_q;
    assign gy_abs     = gy_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_gradient.sv
// Bench for sobel_gradient on an 8x6 image: each accepted interior pixel
// queues its expected result (computed directly from the image) with the
// cycle it is due; every output cycle is matched against that queue.
module tb_sobel_gradient;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int NP = W * H;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pix_in = '0;
    logic       pix_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] gx_abs, gy_abs;
    logic       out_valid, frame_done;

    sobel_gradient #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .SHIFT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .gx_abs     (gx_abs),
        .gy_abs     (gy_abs),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     gx;
        int     gy;
        bit     fd;
        longint due;
    } exp_t;

    exp_t   exp_q[$];
    int     img[H][W];
    longint cyc       = 0;
    int     n_tests   = 0;
    int     n_fail    = 0;
    int     n_results = 0;
    int     n_fd      = 0;

    // Expected |G|/4 clamped to 255 for the centre at (c, r).
    function automatic void model(input int r, input int c, output int gx, output int gy);
        int p[3][3];
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                p[dr][dc] = img[r - 1 + dr][c - 1 + dc];
        gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        gx = gx / 4;
        gy = gy / 4;
        if (gx > 255) gx = 255;
        if (gy > 255) gy = 255;
    endfunction

    // 0 const, 1 step 0|200, 2 step 200|0, 3 rows 0/255, 4 checkerboard, 5 random
    task automatic make_image(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0: img[r][c] = 100;
                    1: img[r][c] = (c < 4) ? 0 : 200;
                    2: img[r][c] = (c < 4) ? 200 : 0;
                    3: img[r][c] = (r < 3) ? 0 : 255;
                    4: img[r][c] = ((r + c) % 2 == 1) ? 255 : 0;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
    endtask

    // One clock: drive inputs, take the edge, then match the outputs.
    task automatic tick(input bit v, input bit s, input logic [7:0] px);
        exp_t e;
        pix_valid = v;
        sof       = s;
        pix_in    = px;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_result cyc=%0d: out_valid=0, required result gx=%0d gy=%0d due cyc=%0d",
                     cyc, e.gx, e.gy, e.due);
        end
        if (out_valid === 1'b1) begin
            n_results++;
            if (frame_done === 1'b1) n_fd++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_result cyc=%0d: out_valid=1 gx=%0d gy=%0d, required no result",
                         cyc, gx_abs, gy_abs);
            end else begin
                e = exp_q.pop_front();
                if (e.due != cyc || gx_abs !== 8'(e.gx) || gy_abs !== 8'(e.gy) || frame_done !== e.fd) begin
                    n_fail++;
                    $display("FAIL result cyc=%0d: got gx=%0d gy=%0d fd=%0d, required gx=%0d gy=%0d fd=%0d at cyc=%0d",
                             cyc, gx_abs, gy_abs, frame_done, e.gx, e.gy, e.fd, e.due);
                end else begin
                    $display("[TB] result cyc=%0d gx=%0d gy=%0d fd=%0d", cyc, gx_abs, gy_abs, frame_done);
                end
            end
        end else if (frame_done === 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_done_alone cyc=%0d: frame_done=1 with out_valid=0, required 0", cyc);
        end
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    // Send raster pixel i of the current image after 0..gapmax idle cycles.
    task automatic send_pixel(input int i, input int gapmax, input bit abort_prev);
        int   r, c, gx, gy;
        bit   s;
        exp_t e;
        r = i / W;
        c = i % W;
        s = (i == 0);
        if (gapmax > 0) repeat ($urandom_range(0, gapmax)) tick(1'b0, 1'b0, 8'h00);
        if (s && abort_prev) begin
            // Results not yet out when the interrupting sof is accepted are lost.
            while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].due >= cyc + 1)
                void'(exp_q.pop_back());
        end
        if (r >= 2 && c >= 2) begin
            model(r - 1, c - 1, gx, gy);
            e.gx  = gx;
            e.gy  = gy;
            e.fd  = (i == NP - 1);
            e.due = cyc + 1 + 2;
            exp_q.push_back(e);
        end
        tick(1'b1, s, 8'(img[r][c]));
    endtask

    task automatic send_frame(input int gapmax);
        for (int i = 0; i < NP; i++) send_pixel(i, gapmax, 1'b0);
    endtask

    task automatic drain();
        repeat (5) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_counts();
        n_results = 0;
        n_fd      = 0;
    endtask

    task automatic test_reset();
        #23;
        n_tests++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: out_valid=%b frame_done=%b, required 0 0", out_valid, frame_done);
        end
        n_tests++;
        if (gx_abs !== 8'd0 || gy_abs !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_data: gx=%0d gy=%0d, required 0 0", gx_abs, gy_abs);
        end
        @(negedge clk);
        rst = 1'b1;
        tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_constant();
        clear_counts();
        make_image(0);
        send_frame(0);
        drain();
        n_tests++;
        if (n_results != 24 || n_fd != 1) begin
            n_fail++;
            $display("FAIL constant_counts: results=%0d frame_done=%0d, required 24 1", n_results, n_fd);
        end
    endtask

    task automatic test_vertical_step();
        clear_counts();
        make_image(1);
        send_frame(0);
        make_image(2);
        send_frame(0);
        drain();
        n_tests++;
        if (n_results != 48 || n_fd != 2) begin
            n_fail++;
            $display("FAIL vstep_counts: results=%0d frame_done=%0d, required 48 2", n_results, n_fd);
        end
    endtask

    task automatic test_horizontal_and_checker();
        clear_counts();
        make_image(3);
        send_frame(0);
        make_image(4);
        send_frame(0);
        drain();
        n_tests++;
        if (n_results != 48 || n_fd != 2) begin
            n_fail++;
            $display("FAIL hstep_counts: results=%0d frame_done=%0d, required 48 2", n_results, n_fd);
        end
    endtask

    task automatic test_random_frames();
        clear_counts();
        for (int f = 0; f < 3; f++) begin
            make_image(5);
            send_frame(0);
        end
        drain();
        n_tests++;
        if (n_results != 72 || n_fd != 3) begin
            n_fail++;
            $display("FAIL random_counts: results=%0d frame_done=%0d, required 72 3", n_results, n_fd);
        end
    endtask

    task automatic test_gaps();
        clear_counts();
        make_image(1);
        send_frame(3);
        make_image(5);
        send_frame(3);
        drain();
        n_tests++;
        if (n_results != 48 || n_fd != 2) begin
            n_fail++;
            $display("FAIL gaps_counts: results=%0d frame_done=%0d, required 48 2", n_results, n_fd);
        end
    endtask

    task automatic test_async_reset();
        make_image(5);
        for (int i = 0; i < 20; i++) send_pixel(i, 0, 1'b0);
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        exp_q.delete();
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || gx_abs !== 8'd0 || gy_abs !== 8'd0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: out_valid=%b gx=%0d gy=%0d fd=%b, required all 0",
                     out_valid, gx_abs, gy_abs, frame_done);
        end
        tick(1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        clear_counts();
        make_image(1);
        send_frame(0);
        drain();
        n_tests++;
        if (n_results != 24 || n_fd != 1) begin
            n_fail++;
            $display("FAIL after_reset_counts: results=%0d frame_done=%0d, required 24 1", n_results, n_fd);
        end
    endtask

    task automatic test_mid_sof();
        clear_counts();
        make_image(5);
        for (int i = 0; i < 30; i++) send_pixel(i, 0, 1'b0);
        make_image(5);
        send_pixel(0, 0, 1'b1);
        for (int i = 1; i < NP; i++) send_pixel(i, 0, 1'b0);
        make_image(1);
        send_frame(0);
        drain();
        // Aborted frame: triggers at pixels 18-23 and 26-27 are out before the sof.
        n_tests++;
        if (n_results != 8 + 48 || n_fd != 2) begin
            n_fail++;
            $display("FAIL mid_sof_counts: results=%0d frame_done=%0d, required 56 2", n_results, n_fd);
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_vertical_step();
        test_horizontal_and_checker();
        test_random_frames();
        test_gaps();
        test_async_reset();
        test_mid_sof();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expected: %0d results never seen, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
